// File: rtl/pool_controller_pkg.sv
// Shared definitions for the 2x2 max-pooling controller: defaults, address width
// and FSM state encoding.
package pool_controller_pkg;

   localparam int DATA_W_DEFAULT = 16;
   localparam int IMG_W_DEFAULT  = 256;
   localparam int ADDR_W         = 20;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      RD3,
      LAST,
      WR,
      DONE
   } state_t;

endpackage

// File: rtl/pool_max_reg.sv
// Running-maximum register for one 2x2 window: unconditional load of the first
// sample, then replacement only by a strictly greater signed value.
module pool_max_reg
   import pool_controller_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              update,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (update && ($signed(d) > $signed(q))) begin
         // Ties keep the held value; the pooled result is the same either way.
         q <= d;
      end
   end

endmodule

// File: rtl/pool_controller.sv
// 2x2 stride-2 max-pooling controller: walks the conv result RAM window by window
// and writes one pooled word per six cycles to the pooled RAM.
module pool_controller
   import pool_controller_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int IMG_W  = IMG_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [19:0]       RAM_A,
   output logic              RAM_OE,
   input  logic [DATA_W-1:0] RAM_Q,
   output logic [19:0]       POOL_A,
   output logic              POOL_WE,
   output logic [DATA_W-1:0] POOL_D,
   output logic              busy,
   output logic              done
);

   localparam int                HALF     = IMG_W / 2;
   localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(HALF);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HALF - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] prow, pcol;
   logic [ADDR_W-1:0] rd_base;
   logic              last_word;
   logic              max_load, max_update;
   logic [DATA_W-1:0] max_q;

   // Top-left pixel of the current window; the other three are fixed offsets.
   assign rd_base   = (prow << 1) * IMG_W_A + (pcol << 1);
   assign last_word = (prow == LAST_IDX) && (pcol == LAST_IDX);
   assign busy      = (state != IDLE) && (state != DONE);

   // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         prow  <= '0;
         pcol  <= '0;
      end else begin
         state <= state_nx;
         if (state == WR) begin
            if (pcol == LAST_IDX) begin
               pcol <= '0;
               prow <= prow + 1'b1;
            end else begin
               pcol <= pcol + 1'b1;
            end
         end else if (state == DONE) begin
            prow <= '0;
            pcol <= '0;
         end
      end
   end

   // NOTE: every combinational output gets a default first, so no branch can infer a latch.
   always_comb begin
      state_nx   = state;
      RAM_A      = '0;
      RAM_OE     = 1'b0;
      POOL_A     = '0;
      POOL_WE    = 1'b0;
      POOL_D     = '0;
      done       = 1'b0;
      max_load   = 1'b0;
      max_update = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RD0;
         RD0: begin
            RAM_OE   = 1'b1;
            RAM_A    = rd_base;
            state_nx = RD1;
         end
         RD1: begin
            RAM_OE   = 1'b1;
            RAM_A    = rd_base + 1'b1;
            max_load = 1'b1;
            state_nx = RD2;
         end
         RD2: begin
            RAM_OE     = 1'b1;
            RAM_A      = rd_base + IMG_W_A;
            max_update = 1'b1;
            state_nx   = RD3;
         end
         RD3: begin
            RAM_OE     = 1'b1;
            RAM_A      = rd_base + IMG_W_A + 1'b1;
            max_update = 1'b1;
            state_nx   = LAST;
         end
         // Read data lags the address by one cycle, so the RD3 sample lands here.
         LAST: begin
            max_update = 1'b1;
            state_nx   = WR;
         end
         WR: begin
            POOL_WE  = 1'b1;
            POOL_A   = prow * HALF_A + pcol;
            POOL_D   = max_q;
            state_nx = last_word ? DONE : RD0;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   pool_max_reg #(
      .DATA_W(DATA_W)
   ) u_max (
      .clk   (clk),
      .rst   (rst),
      .load  (max_load),
      .update(max_update),
      .d     (RAM_Q),
      .q     (max_q)
   );

endmodule

// File: tb/tb_pool_controller.sv
// Self-checking bench for pool_controller on a 16x16 image: RAM model, window
// vector table, scoreboard of expected pooled writes, and reset/start corner cases.
module tb_pool_controller;

   localparam int DATA_W = 16;
   localparam int IMG_W  = 16;
   localparam int HALF   = IMG_W / 2;
   localparam int WORDS  = HALF * HALF;
   localparam int NPIX   = IMG_W * IMG_W;
   localparam int WAIT_MAX = 6 * WORDS + 50;
   localparam int NVEC   = 6;

   typedef struct packed {
      logic [3:0][15:0] w0;
      logic [3:0][15:0] w1;
      logic [15:0]      e0;
      logic [15:0]      e1;
   } vec_t;

   typedef struct {
      logic [19:0] addr;
      logic [15:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [19:0]       RAM_A;
   logic              RAM_OE;
   logic [DATA_W-1:0] RAM_Q = '0;
   logic [19:0]       POOL_A;
   logic              POOL_WE;
   logic [DATA_W-1:0] POOL_D;
   logic              busy;
   logic              done;

   logic [15:0] mem [0:NPIX-1];
   vec_t        vecs [NVEC];
   exp_t        sb [$];

   int checks = 0;
   int errors = 0;
   int pass_cycles, first_we, we_count, done_count;

   pool_controller #(
      .DATA_W(DATA_W),
      .IMG_W (IMG_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .RAM_A  (RAM_A),
      .RAM_OE (RAM_OE),
      .RAM_Q  (RAM_Q),
      .POOL_A (POOL_A),
      .POOL_WE(POOL_WE),
      .POOL_D (POOL_D),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data appears the cycle after the enabled address.
   always @(posedge clk) begin
      if (RAM_OE) RAM_Q <= (int'(RAM_A) < NPIX) ? mem[int'(RAM_A)] : 16'hDEAD;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] s16(input int v);
      return v[15:0];
   endfunction

   task automatic set_vec(input int i, input int a0, a1, a2, a3,
                          input int b0, b1, b2, b3, input int e0, e1);
      vecs[i].w0[0] = s16(a0); vecs[i].w0[1] = s16(a1);
      vecs[i].w0[2] = s16(a2); vecs[i].w0[3] = s16(a3);
      vecs[i].w1[0] = s16(b0); vecs[i].w1[1] = s16(b1);
      vecs[i].w1[2] = s16(b2); vecs[i].w1[3] = s16(b3);
      vecs[i].e0 = s16(e0);
      vecs[i].e1 = s16(e1);
   endtask

   task automatic load_mem(input int i);
      for (int a = 0; a < NPIX; a++) mem[a] = s16(a % 32768);
      mem[0]         = vecs[i].w0[0];
      mem[1]         = vecs[i].w0[1];
      mem[IMG_W]     = vecs[i].w0[2];
      mem[IMG_W + 1] = vecs[i].w0[3];
      mem[2]         = vecs[i].w1[0];
      mem[3]         = vecs[i].w1[1];
      mem[IMG_W + 2] = vecs[i].w1[2];
      mem[IMG_W + 3] = vecs[i].w1[3];
   endtask

   function automatic logic [15:0] model_max(input int a);
      int base;
      logic signed [15:0] m, v;
      base = 2 * (a / HALF) * IMG_W + 2 * (a % HALF);
      m = mem[base];
      v = mem[base + 1];         if (v > m) m = v;
      v = mem[base + IMG_W];     if (v > m) m = v;
      v = mem[base + IMG_W + 1]; if (v > m) m = v;
      return m;
   endfunction

   task automatic push_expected(input logic [15:0] e0, input logic [15:0] e1);
      exp_t e;
      sb.delete();
      for (int a = 0; a < WORDS; a++) begin
         e.addr = 20'(a);
         e.data = (a == 0) ? e0 : (a == 1) ? e1 : model_max(a);
         sb.push_back(e);
      end
   endtask

   // Output monitor: invariants every cycle, scoreboard pop on each pooled write.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("oe_we_exclusive", 32'(RAM_OE & POOL_WE), 32'd0);
         if (!RAM_OE) check("ram_a_zero_when_idle", 32'(RAM_A), 32'd0);
         if (!POOL_WE) begin
            check("pool_a_zero_when_idle", 32'(POOL_A), 32'd0);
            check("pool_d_zero_when_idle", 32'(POOL_D), 32'd0);
         end
         if (done) check("busy_low_in_done", 32'(busy), 32'd0);
         if (RAM_OE || POOL_WE) check("busy_high_when_active", 32'(busy), 32'd1);
         if (busy || done) pass_cycles++;
         if (done) done_count++;
         if (POOL_WE) begin
            we_count++;
            if (first_we == 0) first_we = pass_cycles;
            check("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("pool_addr", 32'(POOL_A), 32'(e.addr));
               check("pool_data", 32'(POOL_D), 32'(e.data));
            end
         end
      end
   end

   task automatic clear_counts();
      pass_cycles = 0;
      first_we    = 0;
      we_count    = 0;
      done_count  = 0;
   endtask

   task automatic run_pass(input int i, input bit poke);
      bit finished;
      load_mem(i);
      push_expected(vecs[i].e0, vecs[i].e1);
      clear_counts();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < WAIT_MAX && !finished; c++) begin
         @(negedge clk);
         if (poke && c == 50) start = 1'b1;
         else if (poke && c == 51) start = 1'b0;
         if (done) begin
            finished = 1'b1;
            if (poke) start = 1'b1;
         end
      end
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("pass_completed", 32'(finished), 32'd1);
      check("write_count", 32'(we_count), 32'(WORDS));
      check("done_pulses", 32'(done_count), 32'd1);
      check("pass_cycles", 32'(pass_cycles), 32'(6 * WORDS + 1));
      check("first_write_cycle", 32'(first_we), 32'd6);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("idle_after_pass", 32'({busy, done, RAM_OE, POOL_WE}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      clear_counts();
      #2;
      check("reset_ctrl_outputs", 32'({RAM_OE, POOL_WE, busy, done}), 32'd0);
      check("reset_ram_a", 32'(RAM_A), 32'd0);
      check("reset_pool_a", 32'(POOL_A), 32'd0);
      check("reset_pool_d", 32'(POOL_D), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Window (0,0) = {r0c0, r0c1, r1c0, r1c1}, window (0,1) likewise.
      set_vec(0, 0, 1, 16, 17,                2, 3, 18, 19,        17, 19);
      set_vec(1, -5, -3, -7, -9,              -1, 5, -2, 3,        -3, 5);
      set_vec(2, 200, 200, 200, 200,          100, 100, 100, 100,  200, 100);
      set_vec(3, 7, 1, 2, 3,                  1, 2, 3, 9,          7, 9);
      set_vec(4, -32768, -32768, -32768, -1,  32767, -1, 0, 5,     -1, 32767);
      set_vec(5, 4, 9, 9, 2,                  0, 0, 0, 0,          9, 0);

      for (int i = 0; i < NVEC; i++) run_pass(i, i == 0);

      // Reset in RD2 of pooled pixel 10: abandon the pass, restart from pixel 0.
      load_mem(0);
      push_expected(vecs[0].e0, vecs[0].e1);
      clear_counts();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (62) @(posedge clk);
      #1;
      check("rd2_pixel10_oe", 32'(RAM_OE), 32'd1);
      check("rd2_pixel10_addr", 32'(RAM_A), 32'((2 * (10 / HALF) + 1) * IMG_W + 2 * (10 % HALF)));
      check("writes_before_reset", 32'(we_count), 32'd10);
      rst = 1'b1;
      #1;
      check("async_reset_ctrl", 32'({RAM_OE, POOL_WE, busy, done}), 32'd0);
      check("async_reset_ram_a", 32'(RAM_A), 32'd0);
      check("async_reset_pool_a", 32'(POOL_A), 32'd0);
      check("async_reset_pool_d", 32'(POOL_D), 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("no_write_after_reset", 32'(we_count), 32'd10);
      check("idle_after_reset", 32'(busy), 32'd0);
      run_pass(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
